rv32f_decoder: RTL

Decode stage for the single-precision FP unit: accepts raw 32-bit instruction words on a valid/ready stream and emits one registered, fully-resolved FP micro-op per instruction.
- Resolves the dynamic rounding mode against the live frm value.
- Detects illegal RV32F encodings.
- Absorbs downstream back-pressure through a 2-entry skid buffer.
- Sits between the integer front-end dispatch and the FPU execute pipeline.

---
 rtl/rv32f_pkg.sv | 150 +++++++++++++++
 rtl/rv32f_skid_buffer.sv | 59 +++++
 rtl/rv32f_decoder.sv | 69 ++++++
 3 files changed

// File: rtl/rv32f_pkg.sv
// Shared RV32F decode types and the combinational instruction decoder.
package rv32f_pkg;

   typedef enum logic [4:0] {
      FLW, FSW, FMADD, FMSUB, FNMSUB, FNMADD, FADD, FSUB, FMUL, FDIV, FSQRT,
      FSGNJ, FSGNJN, FSGNJX, FMIN, FMAX, FCVT_W, FCVT_WU, FMV_X_W, FCLASS,
      FEQ, FLT, FLE, FCVT_S_W, FCVT_S_WU, FMV_W_X, ILLEGAL
   } rv32f_op_t;

   typedef enum logic [2:0] {
      RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100, DYN = 3'b111
   } rv32f_rm_t;

   typedef struct packed {
      rv32f_op_t   code;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rs3;
      logic        rd_int;
      logic        rs1_int;
      logic [2:0]  rm;
      logic [11:0] imm;
      logic        illegal;
   } rv32f_uop_t;

   localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
   localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
   localparam logic [6:0] OPC_FMADD    = 7'b1000011;
   localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
   localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
   localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
   localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

   localparam logic [2:0] RV32F_FUNCT3_FLE_S = 3'b000;
   localparam logic [2:0] RV32F_FUNCT3_FLT_S = 3'b001;
   localparam logic [2:0] RV32F_FUNCT3_FEQ_S = 3'b010;

   // Fully resolve one instruction word; any failed check collapses to an ILLEGAL marker.
   function automatic rv32f_uop_t rv32f_decode(input logic [31:0] instr, input logic [2:0] frm);
      rv32f_uop_t u;
      logic       ok;
      logic       rnd;
      logic [2:0] f3;
      logic [2:0] rm;
      u       = '0;
      u.code  = ILLEGAL;
      u.rd    = instr[11:7];
      u.rs1   = instr[19:15];
      u.rs2   = instr[24:20];
      f3      = instr[14:12];
      ok      = 1'b1;
      rnd     = 1'b0;
      rm      = 3'b000;
      case (instr[6:0])
         OPC_LOAD_FP: begin
            u.code = FLW; ok = (f3 == 3'b010);
            u.rs2 = '0; u.rs1_int = 1'b1; u.imm = instr[31:20];
         end
         OPC_STORE_FP: begin
            u.code = FSW; ok = (f3 == 3'b010);
            u.rd = '0; u.rs1_int = 1'b1; u.imm = {instr[31:25], instr[11:7]};
         end
         OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
            case (instr[3:2])
               2'b00:   u.code = FMADD;
               2'b01:   u.code = FMSUB;
               2'b10:   u.code = FNMSUB;
               default: u.code = FNMADD;
            endcase
            ok = (instr[26:25] == 2'b00); u.rs3 = instr[31:27]; rnd = 1'b1;
         end
         OPC_OP_FP: begin
            if (instr[26:25] != 2'b00) ok = 1'b0;
            case (instr[31:27])
               5'b00000: begin u.code = FADD; rnd = 1'b1; end
               5'b00001: begin u.code = FSUB; rnd = 1'b1; end
               5'b00010: begin u.code = FMUL; rnd = 1'b1; end
               5'b00011: begin u.code = FDIV; rnd = 1'b1; end
               5'b01011: begin
                  u.code = FSQRT; rnd = 1'b1; u.rs2 = '0;
                  if (instr[24:20] != 5'd0) ok = 1'b0;
               end
               5'b00100: begin
                  case (f3)
                     3'b000:  u.code = FSGNJ;
                     3'b001:  u.code = FSGNJN;
                     3'b010:  u.code = FSGNJX;
                     default: ok = 1'b0;
                  endcase
               end
               5'b00101: begin
                  case (f3)
                     3'b000:  u.code = FMIN;
                     3'b001:  u.code = FMAX;
                     default: ok = 1'b0;
                  endcase
               end
               5'b11000: begin
                  u.code = instr[20] ? FCVT_WU : FCVT_W;
                  u.rd_int = 1'b1; u.rs2 = '0; rnd = 1'b1;
                  if (instr[24:21] != 4'd0) ok = 1'b0;
               end
               5'b11010: begin
                  u.code = instr[20] ? FCVT_S_WU : FCVT_S_W;
                  u.rs1_int = 1'b1; u.rs2 = '0; rnd = 1'b1;
                  if (instr[24:21] != 4'd0) ok = 1'b0;
               end
               5'b11100: begin
                  case (f3)
                     3'b000:  u.code = FMV_X_W;
                     3'b001:  u.code = FCLASS;
                     default: ok = 1'b0;
                  endcase
                  u.rd_int = 1'b1; u.rs2 = '0;
                  if (instr[24:20] != 5'd0) ok = 1'b0;
               end
               5'b10100: begin
                  case (f3)
                     RV32F_FUNCT3_FLE_S: u.code = FLE;
                     RV32F_FUNCT3_FLT_S: u.code = FLT;
                     RV32F_FUNCT3_FEQ_S: u.code = FEQ;
                     default:            ok = 1'b0;
                  endcase
                  u.rd_int = 1'b1;
               end
               5'b11110: begin
                  u.code = FMV_W_X; u.rs1_int = 1'b1; u.rs2 = '0;
                  if (instr[24:20] != 5'd0 || f3 != 3'b000) ok = 1'b0;
               end
               default: ok = 1'b0;
            endcase
         end
         default: ok = 1'b0;
      endcase
      // Dynamic rounding takes the live frm; reserved encodings 101/110/111 are rejected.
      if (rnd) begin
         rm = (f3 == DYN) ? frm : f3;
         if (rm == 3'b101 || rm == 3'b110 || rm == 3'b111) ok = 1'b0;
         u.rm = rm;
      end
      if (!ok) begin
         u         = '0;
         u.code    = ILLEGAL;
         u.illegal = 1'b1;
      end
      return u;
   endfunction

endpackage

// File: rtl/rv32f_skid_buffer.sv
// Generic 2-entry valid/ready register slice: output register plus one skid register.
module rv32f_skid_buffer #(
   parameter type T = logic [7:0]
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   logic skid_valid;
   T     skid_data;
   logic accept;
   logic drain;

   // Ready depends only on the skid flop, so op_ready never reaches instr_ready combinationally.
   assign in_ready = !skid_valid;
   assign accept   = in_valid && !skid_valid;
   assign drain    = out_valid && out_ready;

   // Occupancy flags; flush discards both entries and any same-cycle accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (drain) begin
         out_valid  <= skid_valid || accept;
         skid_valid <= 1'b0;
      end else if (accept) begin
         if (out_valid) skid_valid <= 1'b1;
         else           out_valid  <= 1'b1;
      end
   end

   // Payload moves only on accept or drain, keeping the presented op stable while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         skid_data <= '0;
      end else if (!flush) begin
         if (drain) begin
            if (skid_valid)  out_data <= skid_data;
            else if (accept) out_data <= in_data;
         end else if (accept) begin
            if (out_valid) skid_data <= in_data;
            else           out_data  <= in_data;
         end
      end
   end

endmodule

// File: rtl/rv32f_decoder.sv
// RV32F decode stage: decodes instruction words into registered FP micro-ops.
module rv32f_decoder
   import rv32f_pkg::*;
#(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic [2:0]             frm,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   input  logic [31:0]            instr_data,
   output logic                   op_valid,
   input  logic                   op_ready,
   output logic [4:0]             op_code,
   output logic [4:0]             op_rd,
   output logic [4:0]             op_rs1,
   output logic [4:0]             op_rs2,
   output logic [4:0]             op_rs3,
   output logic                   op_rd_int,
   output logic                   op_rs1_int,
   output logic [2:0]             op_rm,
   output logic [11:0]            op_imm,
   output logic                   op_illegal,
   output logic [COUNT_WIDTH-1:0] illegal_count
);

   rv32f_uop_t                 dec_uop;
   rv32f_uop_t                 out_uop;
   logic [COUNT_WIDTH-1:0]     count_reg;

   assign dec_uop = rv32f_decode(instr_data, frm);

   rv32f_skid_buffer #(.T(rv32f_uop_t)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (instr_valid),
      .in_ready  (instr_ready),
      .in_data   (dec_uop),
      .out_valid (op_valid),
      .out_ready (op_ready),
      .out_data  (out_uop)
   );

   assign op_code    = out_uop.code;
   assign op_rd      = out_uop.rd;
   assign op_rs1     = out_uop.rs1;
   assign op_rs2     = out_uop.rs2;
   assign op_rs3     = out_uop.rs3;
   assign op_rd_int  = out_uop.rd_int;
   assign op_rs1_int = out_uop.rs1_int;
   assign op_rm      = out_uop.rm;
   assign op_imm     = out_uop.imm;
   assign op_illegal = out_uop.illegal;

   // Count illegal markers handed downstream (including in a flush cycle), saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (op_valid && op_ready && out_uop.illegal && count_reg != '1) begin
         count_reg <= count_reg + COUNT_WIDTH'(1);
      end
   end

   assign illegal_count = count_reg;

endmodule
